// File: rtl/sha_round_sequencer.sv
// Control sequencer for a SHA-2 style block engine: load words, run rounds, accumulate, write digest.
// Optional macro SEQ_ABORT_EN adds an abort input and a one-cycle aborted indication.
module sha_round_sequencer #(
    parameter int WORDS  = 16,
    parameter int ROUNDS = 64,
    parameter int DIGEST = 8,
    parameter int ADDR_W = 4,
    parameter int K_W    = 6,
    parameter int NB_W   = 8
) (
    input  logic              cnt,
    input  logic              reset,
    input  logic              start,
    input  logic [NB_W-1:0]   num_blocks,
`ifdef SEQ_ABORT_EN
    input  logic              abort,
    output logic              aborted,
`endif
    output logic              busy,
    output logic              load_en,
    output logic [ADDR_W-1:0] in_mem_addr,
    output logic              round_en,
    output logic [K_W-1:0]    k_num,
    output logic              upd_en,
    output logic              en_mem_out,
    output logic [ADDR_W-1:0] out_mem_addr,
    output logic [NB_W-1:0]   block_idx,
    output logic              done
);

    localparam int SW = (K_W > ADDR_W) ? K_W : ADDR_W;
    localparam logic [SW-1:0] LOAD_LAST  = SW'(WORDS - 1);
    localparam logic [SW-1:0] ROUND_LAST = SW'(ROUNDS - 1);
    localparam logic [SW-1:0] WRITE_LAST = SW'(DIGEST - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_ROUND, S_UPDATE, S_WRITE, S_DONE
    } state_t;

    state_t          state, state_nxt;
    logic [SW-1:0]   step;
    logic [NB_W-1:0] blk;
    logic [NB_W-1:0] nb_lat;
    logic            kill;
    logic            last_blk;

`ifdef SEQ_ABORT_EN
    logic aborted_q;
    assign kill    = abort && (state != S_IDLE);
    assign aborted = aborted_q;

    always_ff @(posedge cnt or negedge reset) begin
        if (!reset) aborted_q <= 1'b0;
        else        aborted_q <= kill;
    end
`else
    assign kill = 1'b0;
`endif

    // Comparing against count-1 keeps the block counter from ever needing count itself.
    assign last_blk = (blk == nb_lat - NB_W'(1));

    always_ff @(posedge cnt or negedge reset) begin
        if (!reset) begin
            state  <= S_IDLE;
            step   <= '0;
            blk    <= '0;
            nb_lat <= '0;
        end else begin
            state <= state_nxt;
            if (state_nxt != state)
                step <= '0;
            else if (state == S_LOAD || state == S_ROUND || state == S_WRITE)
                step <= step + SW'(1);
            if (state == S_IDLE && start) begin
                blk    <= '0;
                nb_lat <= (num_blocks == '0) ? NB_W'(1) : num_blocks;
            end else if (state == S_UPDATE && state_nxt == S_LOAD) begin
                blk <= blk + NB_W'(1);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (start) state_nxt = S_LOAD;
            S_LOAD:   if (step == LOAD_LAST) state_nxt = S_ROUND;
            S_ROUND:  if (step == ROUND_LAST) state_nxt = S_UPDATE;
            S_UPDATE: state_nxt = last_blk ? S_WRITE : S_LOAD;
            S_WRITE:  if (step == WRITE_LAST) state_nxt = S_DONE;
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
        if (kill) state_nxt = S_IDLE;
    end

    always_comb begin
        busy         = (state != S_IDLE);
        load_en      = (state == S_LOAD);
        round_en     = (state == S_ROUND);
        upd_en       = (state == S_UPDATE);
        en_mem_out   = (state == S_WRITE);
        done         = (state == S_DONE);
        in_mem_addr  = load_en    ? step[ADDR_W-1:0] : '0;
        k_num        = round_en   ? step[K_W-1:0]    : '0;
        out_mem_addr = en_mem_out ? step[ADDR_W-1:0] : '0;
        block_idx    = blk;
    end

endmodule
